// File: rtl/ce_period_meter_pkg.sv
// Shared constants and FSM encoding for the ce_in period meter.
// Defaults match the clock-enable divider it monitors.
package ce_period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2,
        LOST      = 2'd3
    } state_t;

    localparam int DEF_EXP_PERIOD = 1526;
    localparam int DEF_TOL        = 4;

endpackage

// File: rtl/ce_sync_edge.sv
// Synchroniser for an asynchronous strobe plus rising-edge detector.
// rise is high for one cycle, SYNC_STAGES+1 cycles after din rises.
module ce_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            s_prev <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], din};
            s_prev <= sync[SYNC_STAGES-1];
        end
    end

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_prev;

endmodule

// File: rtl/ce_period_meter.sv
// Measures period and high time of a divided strobe, checks the period
// against an expected value and reports lock, error and loss of signal.
module ce_period_meter
    import ce_period_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int EXP_PERIOD  = DEF_EXP_PERIOD,
    parameter int TOL         = DEF_TOL,
    parameter int TIMEOUT     = 4096,
    parameter int LOCK_N      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ce_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             period_err,
    output logic             err_sticky,
    output logic             lost,
    output logic             locked
);

    localparam int W1     = CNT_W + 1;
    localparam int LOCK_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_N);

    logic s;
    logic rise;

    ce_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ce_in),
        .s    (s),
        .rise (rise)
    );

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d, hi_cnt, hi_d;
    logic [LOCK_W-1:0] lock_cnt, lock_d;
    logic [CNT_W-1:0]  period_d, high_d;
    logic              mv_d, perr_d, sticky_d, lost_d, locked_d;

    // Deviation taken one bit wider and signed so short periods cannot wrap.
    logic signed [CNT_W:0] diff, mag;
    logic                  err;

    always_comb begin
        diff = $signed({1'b0, cnt} + W1'(1)) - $signed(W1'(EXP_PERIOD));
        mag  = diff[CNT_W] ? -diff : diff;
        err  = mag > $signed(W1'(TOL));
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        hi_d     = hi_cnt;
        lock_d   = lock_cnt;
        period_d = period;
        high_d   = high_time;
        mv_d     = 1'b0;
        perr_d   = period_err;
        sticky_d = err_sticky;
        lost_d   = lost;
        locked_d = locked;
        if (!en || state == IDLE) begin
            state_d  = en ? WAIT_EDGE : IDLE;
            cnt_d    = '0;
            hi_d     = '0;
            lock_d   = '0;
            locked_d = 1'b0;
            lost_d   = 1'b0;
            sticky_d = 1'b0;
        end else begin
            case (state)
                WAIT_EDGE: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = '0;
                        hi_d    = CNT_W'(1);
                    end else if (cnt == TO_LAST) begin
                        state_d  = LOST;
                        lost_d   = 1'b1;
                        locked_d = 1'b0;
                        lock_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = cnt + CNT_W'(1);
                        high_d   = hi_cnt;
                        mv_d     = 1'b1;
                        perr_d   = err;
                        cnt_d    = '0;
                        hi_d     = CNT_W'(1);
                        if (err) begin
                            lock_d   = '0;
                            locked_d = 1'b0;
                            sticky_d = 1'b1;
                        end else begin
                            if (lock_cnt != LOCK_MAX)
                                lock_d = lock_cnt + LOCK_W'(1);
                            locked_d = (lock_d == LOCK_MAX);
                        end
                    end else if (cnt == TO_LAST) begin
                        state_d  = LOST;
                        lost_d   = 1'b1;
                        locked_d = 1'b0;
                        lock_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                        hi_d  = hi_cnt + CNT_W'(s);
                    end
                end
                LOST: begin
                    if (rise) begin
                        state_d = MEASURE;
                        lost_d  = 1'b0;
                        cnt_d   = '0;
                        hi_d    = CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            hi_cnt     <= '0;
            lock_cnt   <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            period_err <= 1'b0;
            err_sticky <= 1'b0;
            lost       <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            hi_cnt     <= hi_d;
            lock_cnt   <= lock_d;
            period     <= period_d;
            high_time  <= high_d;
            meas_valid <= mv_d;
            period_err <= perr_d;
            err_sticky <= sticky_d;
            lost       <= lost_d;
            locked     <= locked_d;
        end
    end

endmodule

// File: tb/tb_ce_period_meter.sv
// Randomised self-checking bench for ce_period_meter against a
// period-list model of expected measurements, lock and loss.
module tb_ce_period_meter;

    localparam int CNT_W   = 16;
    localparam int EXP     = 1526;
    localparam int TOL     = 4;
    localparam int TIMEOUT = 4096;
    localparam int LOCK_N  = 4;
    localparam int SYNC    = 2;

    typedef struct packed {
        logic [CNT_W-1:0] p;
        logic [CNT_W-1:0] h;
        logic             e;
    } meas_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic ce_in = 1'b0;
    logic [CNT_W-1:0] period, high_time;
    logic meas_valid, period_err, err_sticky, lost, locked;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int lost_rise_cyc = -1;
    logic prev_lost = 1'b0;
    meas_t obs_q[$];
    meas_t exp_q[$];

    bit have_prev = 1'b0;
    int prev_p = 0;
    int prev_h = 0;
    int m_good = 0;
    bit m_sticky = 1'b0;
    int m_last_p = 0;

    ce_period_meter #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOL),
        .TIMEOUT(TIMEOUT), .LOCK_N(LOCK_N), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ce_in(ce_in),
        .period(period), .high_time(high_time),
        .meas_valid(meas_valid), .period_err(period_err),
        .err_sticky(err_sticky), .lost(lost), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (meas_valid === 1'b1)
            obs_q.push_back({period, high_time, period_err});
        if (lost === 1'b1 && prev_lost !== 1'b1)
            lost_rise_cyc = cyc;
        prev_lost = lost;
    endtask

    function automatic bit bad(input int p);
        return (p > EXP + TOL) || (p < EXP - TOL);
    endfunction

    // Each new rising edge closes the previous period into a measurement.
    task automatic drive_period(input int p, input int h);
        if (have_prev) begin
            exp_q.push_back({CNT_W'(prev_p), CNT_W'(prev_h), bad(prev_p)});
            m_good = bad(prev_p) ? 0 : (m_good < LOCK_N ? m_good + 1 : LOCK_N);
            m_sticky |= bad(prev_p);
            m_last_p = prev_p;
        end
        prev_p = p;
        prev_h = h;
        have_prev = 1'b1;
        last_rise_cyc = cyc;
        for (int i = 0; i < p; i++) begin
            ce_in = (i < h);
            tick();
        end
    endtask

    task automatic drive_rand();
        int p;
        p = EXP - TOL + int'($urandom_range(2 * TOL, 0));
        drive_period(p, int'($urandom_range(p - 1, 1)));
    endtask

    task automatic restart_model();
        have_prev = 1'b0;
        m_good = 0;
        m_sticky = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        repeat (2) tick();
        checks++;
        if ({period, high_time} !== '0) begin
            errors++;
            $display("FAIL reset_meas got p=%0d h=%0d want 0", period, high_time);
        end
        checks++;
        if ({meas_valid, period_err, err_sticky, lost, locked} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {meas_valid, period_err, err_sticky, lost, locked});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({meas_valid, lost, locked} !== 3'b0) begin
            errors++;
            $display("FAIL idle_flags got %b want 000", {meas_valid, lost, locked});
        end
    endtask

    task automatic test_lock();
        meas_t o, x;
        en = 1'b1;
        restart_model();
        repeat (4) tick();
        repeat (4) drive_period(EXP, EXP / 2);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early got %b want 0", locked);
        end
        repeat (2) drive_period(EXP, EXP / 2);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_set got %b want 1", locked);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL lock_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL lock_meas got p=%0d h=%0d e=%0b want p=%0d h=%0d e=%0b",
                         o.p, o.h, o.e, x.p, x.h, x.e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_error();
        meas_t o, x;
        drive_period(EXP + TOL + 1, 765);
        drive_period(EXP + TOL, 700);
        checks++;
        if ({locked, err_sticky} !== 2'b01) begin
            errors++;
            $display("FAIL err_lock got locked=%b sticky=%b want 0 1", locked, err_sticky);
        end
        drive_period(EXP - TOL, 600);
        drive_period(EXP - TOL - 1, 900);
        repeat (6) drive_rand();
        checks++;
        if (locked !== (m_good == LOCK_N)) begin
            errors++;
            $display("FAIL err_relock got %b want %b", locked, m_good == LOCK_N);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL err_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL err_meas got p=%0d h=%0d e=%0b want p=%0d h=%0d e=%0b",
                         o.p, o.h, o.e, x.p, x.h, x.e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_lost();
        meas_t o, x;
        lost_rise_cyc = -1;
        drive_period(TIMEOUT + 20, EXP / 2);
        checks++;
        if (lost_rise_cyc != last_rise_cyc + SYNC + 1 + TIMEOUT) begin
            errors++;
            $display("FAIL lost_time got %0d want %0d", lost_rise_cyc,
                     last_rise_cyc + SYNC + 1 + TIMEOUT);
        end
        checks++;
        if ({lost, locked} !== 2'b10) begin
            errors++;
            $display("FAIL lost_flags got lost=%b locked=%b want 1 0", lost, locked);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL lost_pre_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        obs_q.delete();
        exp_q.delete();
        have_prev = 1'b0;
        m_good = 0;
        drive_period(EXP, EXP / 2);
        checks++;
        if (lost !== 1'b0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL lost_clear got lost=%b meas=%0d want 0 0", lost, obs_q.size());
        end
        repeat (2) drive_rand();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL lost_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL lost_meas got p=%0d h=%0d e=%0b want p=%0d h=%0d e=%0b",
                         o.p, o.h, o.e, x.p, x.h, x.e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_en_drop();
        meas_t o, x;
        checks++;
        if (err_sticky !== m_sticky) begin
            errors++;
            $display("FAIL en_pre_sticky got %b want %b", err_sticky, m_sticky);
        end
        ce_in = 1'b1;
        tick();
        tick();
        en = 1'b0;
        tick();
        checks++;
        if ({meas_valid, locked, err_sticky, lost} !== 4'b0) begin
            errors++;
            $display("FAIL en_drop_flags got %b want 0000",
                     {meas_valid, locked, err_sticky, lost});
        end
        checks++;
        if (period !== CNT_W'(m_last_p)) begin
            errors++;
            $display("FAIL en_drop_period got %0d want %0d", period, m_last_p);
        end
        repeat (EXP / 2) tick();
        ce_in = 1'b0;
        repeat (EXP / 2) tick();
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL en_off_meas got %0d want 0", obs_q.size());
        end
        obs_q.delete();
        en = 1'b1;
        restart_model();
        repeat (3) drive_rand();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL en_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL en_meas got p=%0d h=%0d e=%0b want p=%0d h=%0d e=%0b",
                         o.p, o.h, o.e, x.p, x.h, x.e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        meas_t o, x;
        ce_in = 1'b1;
        repeat (100) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({period, high_time} !== '0 ||
            {meas_valid, period_err, err_sticky, lost, locked} !== 5'b0) begin
            errors++;
            $display("FAIL rst_async got p=%0d h=%0d flags=%b want 0", period, high_time,
                     {meas_valid, period_err, err_sticky, lost, locked});
        end
        ce_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        restart_model();
        repeat (2) drive_rand();
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL rst_count got %0d want 1", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL rst_meas got p=%0d h=%0d e=%0b want p=%0d h=%0d e=%0b",
                         o.p, o.h, o.e, x.p, x.h, x.e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_short();
        meas_t o, x;
        repeat (6) drive_period(3, 1);
        checks++;
        if ({err_sticky, locked, period_err} !== 3'b101) begin
            errors++;
            $display("FAIL short_flags got sticky=%b locked=%b err=%b want 1 0 1",
                     err_sticky, locked, period_err);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL short_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL short_meas got p=%0d h=%0d e=%0b want p=%0d h=%0d e=%0b",
                         o.p, o.h, o.e, x.p, x.h, x.e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_lock();
        test_error();
        test_lost();
        test_en_drop();
        test_reset_mid();
        test_short();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ce_period_meter.md
Name: ce_period_meter

Overview:
- Receive-side counterpart of the clock-enable divider: consumes a divided enable/strobe (ce_in) and measures its period and high time in clk cycles.
- Checks the measured period against an expected value with a tolerance, and reports lock, per-measurement error and loss of signal.
- Sits beside the divider as a self-check / bring-up monitor. ce_in may come from another clock domain, so it is synchronised internally.

Parameters:
- CNT_W, 16, width of cycle counters and measurement outputs.
- EXP_PERIOD, 1526, expected ce_in period in clk cycles.
- TOL, 4, allowed absolute period deviation (inclusive).
- TIMEOUT, 4096, cycles without a rising edge before signal is declared lost; must be < 2^CNT_W.
- LOCK_N, 4, consecutive in-tolerance measurements required to assert locked.
- SYNC_STAGES, 2, synchroniser depth (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  measurement enable
- ce_in  in  1  strobe under measurement (asynchronous to clk)
- period  out  CNT_W  last measured period (cycles between rising edges)
- high_time  out  CNT_W  last measured high cycles within that period
- meas_valid  out  1  one-cycle pulse: period/high_time/period_err updated
- period_err  out  1  last measurement outside EXP_PERIOD±TOL
- err_sticky  out  1  any period_err since en rose
- lost  out  1  no rising edge for TIMEOUT cycles
- locked  out  1  LOCK_N consecutive good measurements, no loss since

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. All outputs and state reset to 0; FSM resets to IDLE.
- Synchroniser: SYNC_STAGES flops (reset 0), then a previous-value flop.
  - rise = s & ~s_prev. The synchronised level is s.
  - Edge-detect latency is SYNC_STAGES+1 cycles from ce_in.
- FSM states: IDLE, WAIT_EDGE, MEASURE, LOST.
  - IDLE: cnt=0, hi_cnt=0, lock_cnt=0, locked=0, lost=0, err_sticky=0. period and high_time retain their values. en=1 -> WAIT_EDGE.
  - WAIT_EDGE: cnt increments each cycle.
    - rise -> MEASURE, with cnt<=0 and hi_cnt<=1.
    - cnt==TIMEOUT-1 without rise -> LOST.
  - MEASURE, on a rise cycle:
    - period<=cnt+1, high_time<=hi_cnt, meas_valid<=1.
    - period_err<=(|cnt+1-EXP_PERIOD| > TOL).
    - cnt<=0, hi_cnt<=1.
  - MEASURE, on any other cycle:
    - cnt<=cnt+1.
    - hi_cnt<=hi_cnt+s.
    - cnt==TIMEOUT-1 -> LOST.
  - LOST: lost=1, locked=0, lock_cnt=0, counters held.
    - rise -> MEASURE, with lost<=0, cnt<=0, hi_cnt<=1.
    - The first rise out of WAIT_EDGE or LOST produces no measurement.
- Lock counter:
  - On meas_valid with no error: lock_cnt increments, saturating at LOCK_N. locked=1 when lock_cnt reaches LOCK_N.
  - On meas_valid with error: lock_cnt<=0, locked<=0, err_sticky<=1.
- en=0 in any state -> IDLE next cycle. This takes priority over a same-cycle rise or timeout: no meas_valid is produced.
- A rise on the timeout cycle wins over the timeout.
- Difference arithmetic is done at CNT_W+1 bits, signed, to avoid wrap.
- Outputs are registered. meas_valid is high exactly 1 cycle, aligned with the updated period, high_time and period_err.
- Asserting rst_n low mid-measurement clears everything immediately. After release, the block restarts from IDLE.

Decomposition:
- Shared package holds:
  - FSM state encoding localparams (IDLE=2'd0, WAIT_EDGE=2'd1, MEASURE=2'd2, LOST=2'd3).
  - Default EXP_PERIOD and TOL constants shared with the divider.
- One sub-module: ce_sync_edge, containing the synchroniser and rise detector. Parameter SYNC_STAGES; outputs s and rise.

Test Plan:
- Divider-style ce_in (period 1526, high 763, en=1):
  - meas_valid on the 2nd and each later rise, with period=1526, high_time=763, period_err=0.
  - locked=1 after the 4th valid measurement.
- After lock, a single period of 1531:
  - That measurement reports period=1531, period_err=1.
  - locked drops to 0 the next cycle and err_sticky=1.
  - A period of 1530 is accepted (error 0).
- ce_in held low after lock:
  - lost=1 exactly TIMEOUT cycles after the last rise cycle, and locked=0.
  - The next rise clears lost with no meas_valid; the following rise measures normally.
- en deasserted on the same cycle a rise is detected:
  - No meas_valid; next cycle FSM=IDLE, locked=0, err_sticky=0, period retained.
- rst_n pulsed low mid-period:
  - All outputs 0 asynchronously.
  - After release with en=1, the first two rises yield exactly one measurement.
- ce_in with high time 1 cycle, period 3: period=3, high_time=1 each valid measurement, with period_err=1 for the default EXP_PERIOD.
